// File: rtl/mem_arbiter.sv
// Fixed-priority arbiter for the shared single-port RAM: the CPU wins ties, and a saturating
// wait counter lets the debug/loader port through after MAX_WAIT consecutive CPU grants.
//   state  | meaning
//   IDLE   | arbitrate; on a grant, latch the request and present it to the RAM
//   ACCESS | RAM cycle; write strobe active for writes
//   RESP   | ack pulse to the owner; read data valid
module mem_arbiter #(
    parameter int AW       = 8,
    parameter int DW       = 16,
    parameter int MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_ack,
    output logic [DW-1:0] cpu_rdata,
    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] dbg_wdata,
    output logic          dbg_ack,
    output logic [DW-1:0] dbg_rdata,
    output logic [AW-1:0] mem_addr,
    output logic          mem_write,
    output logic [DW-1:0] mem_din,
    input  logic [DW-1:0] mem_dout,
    output logic          busy
);

    localparam int WW = $clog2(MAX_WAIT + 1);
    localparam logic [WW-1:0] WAIT_LIMIT = WW'(MAX_WAIT);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t        state;
    state_t        state_next;
    logic [WW-1:0] dbg_wait;
    logic          owner;     // 0 = CPU, 1 = debug
    logic          lat_we;
    logic          grant_cpu;
    logic          grant_dbg;
    logic          sel_we;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        grant_cpu  = 1'b0;
        grant_dbg  = 1'b0;
        sel_we     = cpu_we;
        sel_addr   = cpu_addr;
        sel_wdata  = cpu_wdata;
        case (state)
            IDLE: begin
                grant_cpu = cpu_req && (!dbg_req || (dbg_wait < WAIT_LIMIT));
                grant_dbg = dbg_req && !grant_cpu;
                if (grant_dbg) begin
                    sel_we    = dbg_we;
                    sel_addr  = dbg_addr;
                    sel_wdata = dbg_wdata;
                end
                if (grant_cpu || grant_dbg) begin
                    state_next = ACCESS;
                end
            end
            ACCESS:  state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dbg_wait  <= '0;
            owner     <= 1'b0;
            lat_we    <= 1'b0;
            mem_addr  <= '0;
            mem_din   <= '0;
            mem_write <= 1'b0;
            cpu_ack   <= 1'b0;
            dbg_ack   <= 1'b0;
            cpu_rdata <= '0;
            dbg_rdata <= '0;
            busy      <= 1'b0;
        end else begin
            cpu_ack <= 1'b0;
            dbg_ack <= 1'b0;
            busy    <= (state_next != IDLE);
            if (grant_cpu || grant_dbg) begin
                owner     <= grant_dbg;
                lat_we    <= sel_we;
                mem_addr  <= sel_addr;
                mem_din   <= sel_wdata;
                mem_write <= sel_we;
            end
            if (grant_dbg) begin
                dbg_wait <= '0;
            end else if (grant_cpu && dbg_req && (dbg_wait < WAIT_LIMIT)) begin
                dbg_wait <= dbg_wait + 1'b1;
            end
            if (state == ACCESS) begin
                mem_write <= 1'b0;
                if (owner) begin
                    dbg_ack <= 1'b1;
                    if (!lat_we) begin
                        dbg_rdata <= mem_dout;
                    end
                end else begin
                    cpu_ack <= 1'b1;
                    if (!lat_we) begin
                        cpu_rdata <= mem_dout;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small RAM model whose read data follows mem_addr
// within the cycle, so it is settled by the capture edge one cycle after the address.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we, dbg_req, dbg_we;
    logic [7:0]  cpu_addr, dbg_addr, mem_addr;
    logic [15:0] cpu_wdata, dbg_wdata, cpu_rdata, dbg_rdata, mem_din, mem_dout;
    logic        cpu_ack, dbg_ack, mem_write, busy;

    logic [15:0] ram [0:255];
    logic        pl_en = 1'b0;
    logic [7:0]  pl_addr = '0;
    logic [15:0] pl_data = '0;

    int vectors = 0;
    int miscompares = 0;

    mem_arbiter #(.AW(8), .DW(16), .MAX_WAIT(4)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
        .mem_addr(mem_addr), .mem_write(mem_write), .mem_din(mem_din), .mem_dout(mem_dout),
        .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_write) ram[mem_addr] <= mem_din;
        else if (pl_en) ram[pl_addr] <= pl_data;
    end
    assign mem_dout = ram[mem_addr];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [7:0] a, input logic [15:0] d);
        pl_addr = a;
        pl_data = d;
        pl_en   = 1'b1;
        tick();
        pl_en   = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0;
        preload(8'h05, 16'hABCD);
        preload(8'h10, 16'h0000);
        preload(8'h20, 16'h5A5A);
        preload(8'h30, 16'h0F0F);
        preload(8'h40, 16'h1111);
        chk("rst_busy", busy, 0);
        chk("rst_mem_write", mem_write, 0);
        chk("rst_acks", {cpu_ack, dbg_ack}, 0);
        chk("rst_rdata", {cpu_rdata, dbg_rdata}, 0);
        reset = 1'b0;
        tick();

        // 1: CPU read of 0x05
        cpu_req = 1; cpu_we = 0; cpu_addr = 8'h05;
        tick();
        chk("t1_mem_addr", mem_addr, 8'h05);
        chk("t1_busy_c1", busy, 1);
        chk("t1_ack_c1", cpu_ack, 0);
        cpu_req = 0;
        tick();
        chk("t1_cpu_ack", cpu_ack, 1);
        chk("t1_cpu_rdata", cpu_rdata, 16'hABCD);
        chk("t1_dbg_ack", dbg_ack, 0);
        tick();
        chk("t1_busy_c3", busy, 0);
        chk("t1_ack_c3", cpu_ack, 0);

        // 2: debug write then CPU read-back
        dbg_req = 1; dbg_we = 1; dbg_addr = 8'h10; dbg_wdata = 16'h1234;
        tick();
        chk("t2_mem_write", mem_write, 1);
        chk("t2_mem_addr", mem_addr, 8'h10);
        chk("t2_mem_din", mem_din, 16'h1234);
        chk("t2_dbg_ack_early", dbg_ack, 0);
        dbg_req = 0;
        tick();
        chk("t2_mem_write_off", mem_write, 0);
        chk("t2_dbg_ack", dbg_ack, 1);
        chk("t2_dbg_rdata_kept", dbg_rdata, 16'h0000);
        tick();
        cpu_req = 1; cpu_we = 0; cpu_addr = 8'h10;
        tick();
        cpu_req = 0;
        tick();
        chk("t2_readback_ack", cpu_ack, 1);
        chk("t2_readback", cpu_rdata, 16'h1234);
        tick();

        // 3: both requesting continuously
        reset = 1; tick(); reset = 0;
        cpu_req = 1; cpu_we = 0; cpu_addr = 8'h05;
        dbg_req = 1; dbg_we = 0; dbg_addr = 8'h10;
        for (int i = 0; i < 10; i++) begin
            logic exp_dbg;
            logic [31:0] exp_wait;
            exp_dbg  = ((i % 5) == 4);
            exp_wait = exp_dbg ? 0 : (i % 5) + 1;
            tick();
            chk($sformatf("t3_wait_%0d", i), dut.dbg_wait, exp_wait);
            chk($sformatf("t3_noack_access_%0d", i), {cpu_ack, dbg_ack}, 0);
            tick();
            chk($sformatf("t3_grant_%0d", i), {cpu_ack, dbg_ack}, exp_dbg ? 2'b01 : 2'b10);
            tick();
            chk($sformatf("t3_idle_%0d", i), {busy, cpu_ack, dbg_ack}, 0);
        end
        cpu_req = 0; dbg_req = 0;
        tick();

        // 4: address change during ACCESS is ignored
        cpu_req = 1; cpu_we = 0; cpu_addr = 8'h20;
        tick();
        cpu_addr = 8'h30;
        chk("t4_addr_access", mem_addr, 8'h20);
        tick();
        cpu_req = 0;
        chk("t4_addr_resp", mem_addr, 8'h20);
        chk("t4_rdata", cpu_rdata, 16'h5A5A);
        tick();

        // 5: reset during ACCESS of a write
        cpu_req = 1; cpu_we = 1; cpu_addr = 8'h40; cpu_wdata = 16'hBEEF;
        tick();
        chk("t5_write_on", mem_write, 1);
        #2 reset = 1;
        #1;
        chk("t5_write_dropped", mem_write, 0);
        chk("t5_busy_dropped", busy, 0);
        tick();
        chk("t5_no_ack", {cpu_ack, dbg_ack}, 0);
        chk("t5_not_committed", ram[8'h40], 16'h1111);
        reset = 0;
        tick();
        chk("t5_fresh_busy", busy, 1);
        chk("t5_fresh_write", mem_write, 1);
        cpu_req = 0;
        tick();
        chk("t5_fresh_ack", cpu_ack, 1);
        chk("t5_committed", ram[8'h40], 16'hBEEF);
        tick();
        chk("t5_fresh_idle", busy, 0);

        // 6: CPU request arriving while debug is in ACCESS
        dbg_req = 1; dbg_we = 0; dbg_addr = 8'h10;
        tick();
        dbg_req = 0;
        cpu_req = 1; cpu_we = 0; cpu_addr = 8'h05;
        tick();
        chk("t6_dbg_ack", {cpu_ack, dbg_ack}, 2'b01);
        chk("t6_dbg_rdata", dbg_rdata, 16'h1234);
        tick();
        chk("t6_idle", {busy, cpu_ack}, 0);
        tick();
        chk("t6_cpu_granted", {busy, mem_addr}, {1'b1, 8'h05});
        cpu_req = 0;
        tick();
        chk("t6_cpu_ack", {cpu_ack, dbg_ack}, 2'b10);
        chk("t6_cpu_rdata", cpu_rdata, 16'hABCD);
        chk("t6_dbg_rdata_kept", dbg_rdata, 16'h1234);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Arbitrates the single-port instruction/data RAM between two requesters: the CPU state machine (fetch, LDR, STR) and a debug/loader port that preloads and inspects memory. Fixed priority favours the CPU. A saturating wait counter guarantees the debug port is served under continuous CPU traffic. Sits between the CPU/debug logic and the RAM (registered read, 1-cycle latency).

Parameters:
AW, 8, address width (matches 8-bit PC)
DW, 16, data width
MAX_WAIT, 4, number of consecutive CPU grants a waiting debug request tolerates before it wins

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
cpu_req  input  1  CPU access request, level
cpu_we  input  1  1 = write, 0 = read
cpu_addr  input  AW  CPU address
cpu_wdata  input  DW  CPU write data
cpu_ack  output  1  one-cycle completion pulse to CPU
cpu_rdata  output  DW  CPU read data, valid with cpu_ack
dbg_req  input  1  debug access request, level
dbg_we  input  1  1 = write, 0 = read
dbg_addr  input  AW  debug address
dbg_wdata  input  DW  debug write data
dbg_ack  output  1  one-cycle completion pulse to debug port
dbg_rdata  output  DW  debug read data, valid with dbg_ack
mem_addr  output  AW  RAM address
mem_write  output  1  RAM write enable
mem_din  output  DW  RAM write data
mem_dout  input  DW  RAM read data, valid one cycle after mem_addr is presented
busy  output  1  1 whenever state is not IDLE

Behaviour:
- All outputs are registered. Reset value of every output is 0. Reset also forces state IDLE, dbg_wait = 0, and owner = CPU.
- States are IDLE, ACCESS and RESP. Each transaction takes exactly 3 cycles: IDLE -> ACCESS -> RESP -> IDLE.
- IDLE: arbitration on each rising edge.
  - Neither request: stay in IDLE.
  - Only one request: grant it.
  - Both requests: grant CPU if dbg_wait < MAX_WAIT, otherwise grant debug.
- On grant, latch owner, we, addr and wdata. Drive mem_addr and mem_din from the latched values. Set mem_write = latched we. Go to ACCESS.
- ACCESS: mem_write is high for exactly this one cycle (writes only). mem_addr is held. Go to RESP.
- RESP:
  - Pulse the owner's ack for one cycle.
  - On a read, the owner's rdata captures mem_dout at the ACCESS->RESP edge and is valid while ack = 1.
  - On a write, the owner's rdata is unchanged.
  - mem_write = 0. Go to IDLE.
- rdata outputs hold their last captured value until the next read by the same requester. The non-owner's ack and rdata never change.
- Requester inputs (req, we, addr, wdata) are ignored in ACCESS and RESP; only values sampled at the grant edge matter.
- A req still high in IDLE after its ack is a new request, so back-to-back throughput is 1 transaction per 3 cycles.
- dbg_wait:
  - Increments, saturating at MAX_WAIT, on each IDLE grant to CPU while dbg_req = 1.
  - Clears to 0 on each grant to debug.
  - Unchanged otherwise.
- Only one of cpu_ack and dbg_ack is ever high. Neither ack is ever high in IDLE or ACCESS.
- Reset asserted mid-transaction:
  - mem_write, acks and busy drop immediately (asynchronous). The transaction is abandoned with no ack.
  - A write abandoned before the ACCESS edge completes is not committed.
  - After reset is released, requests still high are arbitrated fresh.
- Address arithmetic: none. Addresses pass through unmodified; all AW bits are significant.

Test Plan:
1. Reset, RAM[0x05] = 0xABCD. Assert cpu_req = 1, cpu_we = 0, cpu_addr = 0x05. Required: mem_addr = 0x05 and busy = 1 in cycle 1; cpu_ack = 1 and cpu_rdata = 0xABCD in cycle 2; busy = 0 in cycle 3; dbg_ack stays 0.
2. Debug write dbg_addr = 0x10, dbg_wdata = 0x1234. Required: mem_write = 1 for exactly one cycle with mem_addr = 0x10 and mem_din = 0x1234; dbg_ack one cycle later. A following CPU read of 0x10 returns 0x1234; dbg_rdata is unchanged by the write.
3. Hold cpu_req and dbg_req continuously with MAX_WAIT = 4. Required: grant sequence is CPU, CPU, CPU, CPU, DBG, then repeats. Acks are spaced 3 cycles apart. dbg_wait reads 0 after the DBG grant.
4. Grant a CPU read of 0x20, then change cpu_addr to 0x30 during ACCESS. Required: mem_addr stays 0x20 and returned data is RAM[0x20].
5. Assert reset during ACCESS of a write. Required: mem_write = 0 immediately and no ack issued. After reset is released with cpu_req still high, a fresh 3-cycle transaction completes normally.
6. dbg_req alone, then cpu_req raised in the cycle debug is in ACCESS. Required: debug completes, and CPU is granted in the next IDLE cycle (ack 3 cycles after the debug ack).
